// File: rtl/or_decomposer.sv
// or_decomposer: splits one WIDTH-bit mask into a burst of one-hot beats,
// one per set bit, so that the OR of the burst rebuilds the mask.
// An empty mask produces a single all-zero beat flagged as last.
// Optional build macro ORDEC_MSB_FIRST_EN: emit highest set bit first
// (default build emits lowest set bit first).
module or_decomposer #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDXW-1:0]  out_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             empty_q, empty_d;

    logic [WIDTH-1:0] sel_bit;
    logic [IDXW-1:0]  sel_idx;
    logic             one_left;
    logic             emit;
    logic             in_fire;

    // Select the bit emitted this beat (and its position) from remaining_q.
    always_comb begin
        sel_bit = '0;
        sel_idx = '0;
`ifdef ORDEC_MSB_FIRST_EN
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < WIDTH; i++) begin
            if (remaining_q[i]) sel_idx = IDXW'(i);
        end
        sel_bit = (|remaining_q) ? (WIDTH'(1) << sel_idx) : '0;
`else
        // Two's-complement trick isolates the lowest set bit.
        sel_bit = remaining_q & (~remaining_q + WIDTH'(1));
        // Descending scan: the last hit is the lowest set bit.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (remaining_q[i]) sel_idx = IDXW'(i);
        end
`endif
    end

    // At most one bit left means this beat closes the burst, in either order.
    assign one_left = ((remaining_q & (remaining_q - WIDTH'(1))) == '0);

    // Outputs depend only on registered state (in_ready also looks at out_ready
    // so a new mask can be taken on the closing beat without a bubble).
    always_comb begin
        emit       = (state_q == EMIT);
        out_valid  = emit;
        busy       = emit;
        out_onehot = emit ? sel_bit : '0;
        out_index  = emit ? sel_idx : '0;
        out_last   = emit & (empty_q | one_left);
        in_ready   = ~emit | (out_ready & out_last);
        in_fire    = in_valid & in_ready;
    end

    // Next-state: load on accept, strip emitted bit on each non-final beat.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        empty_d     = empty_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d     = EMIT;
                    remaining_d = in_mask;
                    empty_d     = (in_mask == '0);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (!out_last) begin
                        remaining_d = remaining_q & ~sel_bit;
                    end else if (in_fire) begin
                        // Back-to-back burst: reload and stay in EMIT.
                        remaining_d = in_mask;
                        empty_d     = (in_mask == '0);
                    end else begin
                        state_d     = IDLE;
                        remaining_d = '0;
                        empty_d     = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
                empty_d     = 1'b0;
            end
        endcase
    end

    // State registers with immediate reset; a reset mid-burst drops it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            empty_q     <= empty_d;
        end
    end

endmodule

// File: tb/tb_or_decomposer.sv
// Self-checking bench for or_decomposer (WIDTH=8). Expected beats come from a
// queue model built by scanning the mask bit by bit; honours ORDEC_MSB_FIRST_EN.
module tb_or_decomposer;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_mask;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_onehot;
    logic [IDXW-1:0]  out_index;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] oh;
        logic [IDXW-1:0]  idx;
        logic             last;
    } beat_t;

    beat_t q[$];
    int    vecs;
    int    errs;

    or_decomposer #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_mask    (in_mask),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: list the set bits in emission order, last flag on the final one.
    task automatic push_beats(input logic [WIDTH-1:0] m);
        int n;
        int k;
        beat_t b;
        n = $countones(m);
        if (n == 0) begin
            b.oh = '0; b.idx = '0; b.last = 1'b1;
            q.push_back(b);
            return;
        end
        k = 0;
        for (int j = 0; j < WIDTH; j++) begin
`ifdef ORDEC_MSB_FIRST_EN
            int i = WIDTH - 1 - j;
`else
            int i = j;
`endif
            if (m[i]) begin
                k++;
                b.oh   = '0;
                b.oh[i] = 1'b1;
                b.idx  = i[IDXW-1:0];
                b.last = (k == n);
                q.push_back(b);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rst_idle: valid=%b busy=%b want 0/0", out_valid, busy); end
        vecs++; if (out_onehot !== '0 || out_index !== '0 || out_last !== 1'b0) begin errs++; $display("FAIL rst_outs: oh=%h idx=%0d last=%b want 0/0/0", out_onehot, out_index, out_last); end
        reset = 1'b0;
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        // Start a burst, then hit reset mid-cycle while in_valid is still high.
        in_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rst_burst_start: valid=%b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        vecs++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rst_mid_burst: valid=%b busy=%b want 0/0", out_valid, busy); end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_after_deassert: in_ready=%b want 1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_no_beat: cycle %0d valid=%b want 0", c, out_valid); end
        end
    endtask

    task automatic test_pattern_a6();
        logic [WIDTH-1:0] eoh[4];
        logic [IDXW-1:0]  eidx[4];
        logic [WIDTH-1:0] acc;
`ifdef ORDEC_MSB_FIRST_EN
        eoh[0] = 8'h80; eidx[0] = 3'd7; eoh[1] = 8'h20; eidx[1] = 3'd5;
        eoh[2] = 8'h04; eidx[2] = 3'd2; eoh[3] = 8'h02; eidx[3] = 3'd1;
`else
        eoh[0] = 8'h02; eidx[0] = 3'd1; eoh[1] = 8'h04; eidx[1] = 3'd2;
        eoh[2] = 8'h20; eidx[2] = 3'd5; eoh[3] = 8'h80; eidx[3] = 3'd7;
`endif
        acc = '0;
        in_mask = 8'hA6; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            vecs++;
            if (out_valid !== 1'b1 || out_onehot !== eoh[k] || out_index !== eidx[k] || out_last !== (k == 3)) begin
                errs++;
                $display("FAIL a6_beat%0d: v=%b oh=%h idx=%0d last=%b want 1/%h/%0d/%b", k, out_valid, out_onehot, out_index, out_last, eoh[k], eidx[k], k == 3);
            end
            acc |= out_onehot;
        end
        vecs++; if (acc !== 8'hA6) begin errs++; $display("FAIL a6_or: got %h want a6", acc); end
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL a6_idle: valid=%b busy=%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_empty();
        in_mask = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vecs++;
        if (out_valid !== 1'b1 || out_onehot !== 8'h00 || out_index !== 3'd0 || out_last !== 1'b1) begin
            errs++;
            $display("FAIL empty_beat: v=%b oh=%h idx=%0d last=%b want 1/00/0/1", out_valid, out_onehot, out_index, out_last);
        end
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL empty_idle: valid=%b busy=%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_full_stall();
        int k;
        int cyc;
        k = 0; cyc = 0;
        in_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (k < 8 && cyc < 100) begin
`ifdef ORDEC_MSB_FIRST_EN
            int ei = 7 - k;
`else
            int ei = k;
`endif
            vecs++;
            if (out_valid !== 1'b1 || out_index !== ei[IDXW-1:0] || out_onehot !== (8'h01 << ei) || out_last !== (k == 7)) begin
                errs++;
                $display("FAIL ff_beat%0d: v=%b oh=%h idx=%0d last=%b want idx %0d last %b", k, out_valid, out_onehot, out_index, out_last, ei, k == 7);
            end
            out_ready = (cyc % 3 == 0);
            #1;
            vecs++;
            if (in_ready !== (k == 7 && out_ready)) begin
                errs++;
                $display("FAIL ff_in_ready%0d: got %b want %b", k, in_ready, (k == 7 && out_ready));
            end
            if (out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        vecs++; if (k != 8) begin errs++; $display("FAIL ff_timeout: beats %0d want 8", k); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL ff_idle: valid=%b want 0", out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] eoh[3];
        logic [IDXW-1:0]  eidx[3];
        logic             elast[3];
`ifdef ORDEC_MSB_FIRST_EN
        eoh[0] = 8'h80; eidx[0] = 3'd7; eoh[1] = 8'h01; eidx[1] = 3'd0;
`else
        eoh[0] = 8'h01; eidx[0] = 3'd0; eoh[1] = 8'h80; eidx[1] = 3'd7;
`endif
        eoh[2] = 8'h10; eidx[2] = 3'd4;
        elast[0] = 1'b0; elast[1] = 1'b1; elast[2] = 1'b1;
        in_mask = 8'h81; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            vecs++;
            if (out_valid !== 1'b1 || out_onehot !== eoh[k] || out_index !== eidx[k] || out_last !== elast[k]) begin
                errs++;
                $display("FAIL b2b_beat%0d: v=%b oh=%h idx=%0d last=%b want 1/%h/%0d/%b", k, out_valid, out_onehot, out_index, out_last, eoh[k], eidx[k], elast[k]);
            end
            if (k == 1) begin
                in_mask = 8'h10; in_valid = 1'b1;
                #1;
                vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_accept: in_ready=%b want 1", in_ready); end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_idle: valid=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic             m_ready;
        logic [WIDTH-1:0] acc;
        q.delete();
        acc = '0;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            // Upstream holds an offered mask until it is taken.
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 4))
                    0: in_mask = 8'h00;
                    1: in_mask = 8'hFF;
                    2: in_mask = 8'h01 << $urandom_range(0, 7);
                    default: in_mask = 8'($urandom);
                endcase
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            m_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
            vecs++;
            if (out_valid !== (q.size() != 0)) begin errs++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                vecs++;
                if (out_onehot !== q[0].oh || out_index !== q[0].idx || out_last !== q[0].last) begin
                    errs++;
                    $display("FAIL rnd_beat c%0d: oh=%h idx=%0d last=%b want %h/%0d/%b", c, out_onehot, out_index, out_last, q[0].oh, q[0].idx, q[0].last);
                end
            end
            vecs++;
            if (in_ready !== m_ready) begin errs++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, m_ready); end
            // Advance the model to what the coming edge commits.
            if (out_ready && q.size() != 0) begin
                acc |= q[0].oh;
                void'(q.pop_front());
            end
            if (in_valid && m_ready) begin
                push_beats(in_mask);
                @(negedge clk);
                in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        // Drain whatever is left.
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            void'(q.pop_front());
            @(negedge clk);
        end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rnd_drain: valid=%b want 0", out_valid); end
    endtask

    initial begin
        vecs = 0; errs = 0;
        reset = 1'b1; in_mask = '0; in_valid = 1'b0; out_ready = 1'b1;
        test_reset();
        test_pattern_a6();
        test_empty();
        test_full_stall();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
